// File: rtl/waveform_pkg.sv
// Shared types and constants for the serial waveform checker.
package waveform_pkg;

   localparam int WORD_W = 8;

   localparam logic [WORD_W-1:0] DEF_PAT_EVEN = 8'hCC;
   localparam logic [WORD_W-1:0] DEF_PAT_ODD  = 8'hAA;

   typedef enum logic [1:0] {
      ST_SEARCH,
      ST_VERIFY,
      ST_LOCKED
   } state_t;

endpackage

// File: rtl/wave_deser.sv
// Serial-to-parallel front end: LSB-first shift register plus word-position counter.
module wave_deser
   import waveform_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              bit_in,
   input  logic              bit_valid,
   input  logic              clear_bc,
   output logic [WORD_W-1:0] word,
   output logic              word_done
);

   logic [WORD_W-1:0] sr;
   logic [2:0]        bc;

   // word is the post-shift value, so the checker sees a completed word on the edge that samples its last bit
   assign word      = {bit_in, sr[WORD_W-1:1]};
   assign word_done = bit_valid && (bc == 3'd7);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sr <= '0;
         bc <= '0;
      end else if (bit_valid) begin
         sr <= word;
         bc <= clear_bc ? 3'd0 : bc + 3'd1;
      end
   end

endmodule

// File: rtl/waveform_checker.sv
// Aligns to the alternating even/odd word stream, flags mismatching words and counts errors while locked.
module waveform_checker
   import waveform_pkg::*;
#(
   parameter logic [WORD_W-1:0] PAT_EVEN   = DEF_PAT_EVEN,
   parameter logic [WORD_W-1:0] PAT_ODD    = DEF_PAT_ODD,
   parameter int unsigned       LOCK_COUNT = 4,
   parameter int unsigned       LOSS_COUNT = 3
)(
   input  logic              CLK,
   input  logic              RST,
   input  logic              BIT_IN,
   input  logic              BIT_VALID,
   output logic [WORD_W-1:0] WORD_OUT,
   output logic              WORD_VALID,
   output logic              WORD_ERR,
   output logic              LOCKED,
   output logic [15:0]       ERR_CNT
);

   state_t            state, state_nxt;
   logic              exp_odd, exp_odd_nxt;
   logic [3:0]        good_run, good_run_nxt;
   logic [3:0]        miss_run, miss_run_nxt;
   logic [15:0]       err_cnt_nxt;
   logic [WORD_W-1:0] word_out_nxt;
   logic              word_valid_nxt, word_err_nxt;
   logic              clear_bc;
   logic [WORD_W-1:0] word;
   logic              word_done;
   logic [WORD_W-1:0] expected;
   logic              word_ok;

   wave_deser u_deser (
      .CLK       (CLK),
      .RST       (RST),
      .bit_in    (BIT_IN),
      .bit_valid (BIT_VALID),
      .clear_bc  (clear_bc),
      .word      (word),
      .word_done (word_done)
   );

   assign expected = exp_odd ? PAT_ODD : PAT_EVEN;
   assign word_ok  = (word == expected);
   assign LOCKED   = (state == ST_LOCKED);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= ST_SEARCH;
         exp_odd    <= 1'b0;
         good_run   <= '0;
         miss_run   <= '0;
         ERR_CNT    <= '0;
         WORD_OUT   <= '0;
         WORD_VALID <= 1'b0;
         WORD_ERR   <= 1'b0;
      end else begin
         state      <= state_nxt;
         exp_odd    <= exp_odd_nxt;
         good_run   <= good_run_nxt;
         miss_run   <= miss_run_nxt;
         ERR_CNT    <= err_cnt_nxt;
         WORD_OUT   <= word_out_nxt;
         WORD_VALID <= word_valid_nxt;
         WORD_ERR   <= word_err_nxt;
      end
   end

   // NOTE: every signal driven here gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt      = state;
      exp_odd_nxt    = exp_odd;
      good_run_nxt   = good_run;
      miss_run_nxt   = miss_run;
      err_cnt_nxt    = ERR_CNT;
      word_out_nxt   = WORD_OUT;
      word_valid_nxt = 1'b0;
      word_err_nxt   = 1'b0;
      clear_bc       = 1'b0;

      unique case (state)
         ST_SEARCH: begin
            if (BIT_VALID && (word == PAT_EVEN || word == PAT_ODD)) begin
               state_nxt    = ST_VERIFY;
               clear_bc     = 1'b1;
               good_run_nxt = '0;
               exp_odd_nxt  = (word == PAT_EVEN);
            end
         end
         ST_VERIFY: begin
            if (word_done) begin
               word_valid_nxt = 1'b1;
               word_out_nxt   = word;
               if (word_ok) begin
                  good_run_nxt = good_run + 4'd1;
                  exp_odd_nxt  = !exp_odd;
                  if (good_run + 4'd1 == 4'(LOCK_COUNT)) begin
                     state_nxt    = ST_LOCKED;
                     miss_run_nxt = '0;
                  end
               end else begin
                  word_err_nxt = 1'b1;
                  state_nxt    = ST_SEARCH;
               end
            end
         end
         ST_LOCKED: begin
            if (word_done) begin
               word_valid_nxt = 1'b1;
               word_out_nxt   = word;
               exp_odd_nxt    = !exp_odd;
               if (word_ok) begin
                  miss_run_nxt = '0;
               end else begin
                  word_err_nxt = 1'b1;
                  miss_run_nxt = miss_run + 4'd1;
                  if (ERR_CNT != 16'hFFFF) err_cnt_nxt = ERR_CNT + 16'd1;
                  if (miss_run + 4'd1 == 4'(LOSS_COUNT)) state_nxt = ST_SEARCH;
               end
            end
         end
         default: state_nxt = ST_SEARCH;
      endcase
   end

endmodule

// File: tb/tb_waveform_checker.sv
// Bench for waveform_checker: queue-based reference model compared every cycle, plus literal spot checks.
module tb_waveform_checker;

   localparam logic [7:0] PE = 8'hCC;
   localparam logic [7:0] PO = 8'hAA;
   localparam int         LOCK_N = 4;
   localparam int         LOSS_N = 3;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        BIT_IN = 1'b0;
   logic        BIT_VALID = 1'b0;
   logic [7:0]  WORD_OUT;
   logic        WORD_VALID;
   logic        WORD_ERR;
   logic        LOCKED;
   logic [15:0] ERR_CNT;

   int n_checks = 0;
   int n_pass   = 0;
   bit run      = 1'b0;

   // reference model state
   int         m_state;     // 0 searching, 1 verifying, 2 locked
   bit         win[$];      // last eight valid bits, oldest first
   bit         wq[$];       // bits of the word being collected
   logic [7:0] m_exp;
   int         m_good, m_miss, m_cnt;
   logic [7:0] m_wout;
   bit         m_wv, m_werr;

   waveform_checker #(
      .PAT_EVEN   (PE),
      .PAT_ODD    (PO),
      .LOCK_COUNT (LOCK_N),
      .LOSS_COUNT (LOSS_N)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .BIT_IN     (BIT_IN),
      .BIT_VALID  (BIT_VALID),
      .WORD_OUT   (WORD_OUT),
      .WORD_VALID (WORD_VALID),
      .WORD_ERR   (WORD_ERR),
      .LOCKED     (LOCKED),
      .ERR_CNT    (ERR_CNT)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
   endtask

   function automatic logic [7:0] pack(input bit q[$]);
      logic [7:0] v = '0;
      for (int i = 0; i < 8; i++) v[i] = q[i];
      return v;
   endfunction

   function automatic logic [7:0] other(input logic [7:0] p);
      return (p == PE) ? PO : PE;
   endfunction

   task automatic model_reset();
      m_state = 0;
      win.delete();
      repeat (8) win.push_back(1'b0);
      wq.delete();
      m_exp = PE; m_good = 0; m_miss = 0; m_cnt = 0;
      m_wout = '0; m_wv = 0; m_werr = 0;
   endtask

   // One clock edge of the specification's behaviour, given the inputs sampled at that edge.
   task automatic model_edge(input bit b, input bit v, input bit r);
      logic [7:0] w;
      m_wv = 0; m_werr = 0;
      if (r) begin model_reset(); return; end
      if (!v) return;
      win.push_back(b);
      void'(win.pop_front());
      if (m_state == 0) begin
         w = pack(win);
         if (w == PE || w == PO) begin
            m_state = 1; m_good = 0; m_exp = other(w); wq.delete();
         end
         return;
      end
      wq.push_back(b);
      if (wq.size() < 8) return;
      w = pack(wq);
      wq.delete();
      m_wv = 1; m_wout = w;
      if (m_state == 1) begin
         if (w == m_exp) begin
            m_good++; m_exp = other(m_exp);
            if (m_good == LOCK_N) begin m_state = 2; m_miss = 0; end
         end else begin
            m_werr = 1; m_state = 0;
         end
      end else begin
         m_exp = other(m_exp);
      end
   endtask

   // Locked-state compare uses the expectation before it toggles.
   task automatic model_locked_word(input logic [7:0] w, input logic [7:0] e);
      if (w == e) m_miss = 0;
      else begin
         m_werr = 1; m_miss++;
         if (m_cnt < 65535) m_cnt++;
         if (m_miss == LOSS_N) m_state = 0;
      end
   endtask

   task automatic drive(input bit b, input bit v, input bit r);
      logic [7:0] e_before;
      int         st_before;
      BIT_IN = b; BIT_VALID = v; RST = r;
      @(posedge CLK);
      #1;
      e_before  = m_exp;
      st_before = m_state;
      model_edge(b, v, r);
      if (!r && st_before == 2 && m_wv) model_locked_word(m_wout, e_before);
   endtask

   task automatic send_word(input logic [7:0] w, input bit gaps);
      for (int i = 0; i < 8; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) drive(1'($urandom_range(0, 1)), 1'b0, 1'b0);
         drive(w[i], 1'b1, 1'b0);
      end
   endtask

   task automatic send_clean(input int n, input bit start_odd, input bit gaps);
      bit odd = start_odd;
      for (int k = 0; k < n; k++) begin
         send_word(odd ? PO : PE, gaps);
         odd = !odd;
      end
   endtask

   always @(negedge CLK) begin
      if (run) begin
         check("word_valid", 32'(WORD_VALID), 32'(m_wv));
         check("word_err",   32'(WORD_ERR),   32'(m_werr));
         check("word_out",   32'(WORD_OUT),   32'(m_wout));
         check("locked",     32'(LOCKED),     32'(m_state == 2));
         check("err_cnt",    32'(ERR_CNT),    32'(m_cnt));
      end
   end

   initial begin
      model_reset();
      drive(1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b1);
      run = 1'b1;
      check("rst_word_out", 32'(WORD_OUT), 32'h00);
      check("rst_locked",   32'(LOCKED),   32'h0);
      check("rst_err_cnt",  32'(ERR_CNT),  32'h0);

      // clean stream: 1 search word + 4 verify words reach lock
      send_clean(4, 1'b0, 1'b0);
      check("not_locked_after_4", 32'(LOCKED), 32'h0);
      send_word(PE, 1'b0);
      check("locked_after_5", 32'(LOCKED), 32'h1);
      check("lock_word_out",  32'(WORD_OUT), 32'hCC);
      send_clean(4, 1'b1, 1'b0);

      // single flipped bit in an AA slot
      send_word(8'hAB, 1'b0);
      check("flip_err",     32'(WORD_ERR), 32'h1);
      check("flip_word",    32'(WORD_OUT), 32'hAB);
      check("flip_cnt",     32'(ERR_CNT),  32'h1);
      check("flip_locked",  32'(LOCKED),   32'h1);
      send_clean(4, 1'b0, 1'b0);

      // three zero words drop lock on the third; count is cumulative with the flip above
      send_word(8'h00, 1'b0);
      send_word(8'h00, 1'b0);
      check("loss_still_locked", 32'(LOCKED), 32'h1);
      send_word(8'h00, 1'b0);
      check("loss_locked", 32'(LOCKED),  32'h0);
      check("loss_cnt",    32'(ERR_CNT), 32'h4);
      send_clean(5, 1'b0, 1'b0);
      check("relock",      32'(LOCKED),  32'h1);
      check("relock_cnt",  32'(ERR_CNT), 32'h4);

      // reset mid-word
      drive(1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b1);
      check("midrst_locked", 32'(LOCKED),   32'h0);
      check("midrst_cnt",    32'(ERR_CNT),  32'h0);
      check("midrst_out",    32'(WORD_OUT), 32'h00);
      send_clean(5, 1'b0, 1'b0);
      check("midrst_relock", 32'(LOCKED), 32'h1);

      // error during verify after two good words
      drive(1'b0, 1'b0, 1'b1);
      send_clean(3, 1'b0, 1'b0);
      send_word(8'h55, 1'b0);
      check("verr_err",    32'(WORD_ERR), 32'h1);
      check("verr_locked", 32'(LOCKED),   32'h0);
      check("verr_cnt",    32'(ERR_CNT),  32'h0);
      send_clean(5, 1'b1, 1'b0);
      check("verr_relock", 32'(LOCKED), 32'h1);

      // stream starting three bits into a CC word
      drive(1'b0, 1'b0, 1'b1);
      for (int i = 3; i < 8; i++) drive(PE[i], 1'b1, 1'b0);
      send_word(PO, 1'b0);
      send_clean(3, 1'b0, 1'b0);
      check("offs_not_yet", 32'(LOCKED), 32'h0);
      send_word(PO, 1'b0);
      check("offs_locked",  32'(LOCKED),   32'h1);
      check("offs_word",    32'(WORD_OUT), 32'hAA);

      // gapped BIT_VALID on a clean stream
      drive(1'b0, 1'b0, 1'b1);
      send_clean(5, 1'b0, 1'b1);
      check("gap_locked", 32'(LOCKED), 32'h1);
      send_clean(6, 1'b1, 1'b1);
      check("gap_cnt",    32'(ERR_CNT), 32'h0);
      drive(1'b0, 1'b0, 1'b0);

      run = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
